// File: rtl/calc_port_responder.sv
// Answering end of the calc request/response port: captures a two-cycle
// request, waits LATENCY edges, then returns a one-cycle response code and data.
module calc_port_responder #(
  parameter int LATENCY = 3,
  parameter int DROP_W  = 8
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [0:3]        req_cmd_in,
  input  logic [0:31]       req_data_in,
  output logic [0:1]        out_resp,
  output logic [0:31]       out_data,
  output logic              busy,
  output logic [0:DROP_W-1] drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP2,
    S_EXEC
  } state_e;

  localparam logic [0:3] CMD_NONE = 4'd0;
  localparam logic [0:3] CMD_ADD  = 4'd1;
  localparam logic [0:3] CMD_SUB  = 4'd2;
  localparam logic [0:3] CMD_SHL  = 4'd5;
  localparam logic [0:3] CMD_SHR  = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;

  localparam logic [3:0]        CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [0:DROP_W-1] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [0:3]        cmd_q;
  logic [0:31]       op1_q, op2_q;
  logic [3:0]        cnt_q;
  logic [0:1]        resp_q;
  logic [0:31]       data_q;
  logic [0:DROP_W-1] drop_q;

  logic              cmd_valid;
  logic              capture_op1, capture_op2, finish, drop;
  logic [0:1]        res_code;
  logic [0:31]       res_data;
  logic [32:0]       sum;
  logic [4:0]        shamt;

  assign cmd_valid = (req_cmd_in != CMD_NONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; without it an unlisted state would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_OP2;
      S_OP2:   state_d = S_EXEC;
      S_EXEC:  if (cnt_q == 4'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    capture_op1 = (state_q == S_IDLE) && cmd_valid;
    capture_op2 = (state_q == S_OP2);
    finish      = (state_q == S_EXEC) && (cnt_q == 4'd0);
    drop        = (state_q != S_IDLE) && cmd_valid;
  end

  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, op2_q};
    shamt    = op2_q[27:31];
    res_code = RESP_ERR;
    res_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum[32]) begin
          res_code = RESP_OK;
          res_data = sum[31:0];
        end
      end
      CMD_SUB: begin
        if (op2_q <= op1_q) begin
          res_code = RESP_OK;
          res_data = op1_q - op2_q;
        end
      end
      CMD_SHL: begin
        res_code = RESP_OK;
        res_data = op1_q << shamt;
      end
      CMD_SHR: begin
        res_code = RESP_OK;
        res_data = op1_q >> shamt;
      end
      default: begin
        res_code = RESP_ERR;
        res_data = '0;
      end
    endcase
  end

  // NOTE: operand and counter registers are reset as well so that no X ever
  // reaches the arithmetic or the response outputs after reset.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q  <= CMD_NONE;
      op1_q  <= '0;
      op2_q  <= '0;
      cnt_q  <= '0;
      resp_q <= RESP_NONE;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      if (capture_op1) begin
        cmd_q <= req_cmd_in;
        op1_q <= req_data_in;
      end
      if (capture_op2) begin
        op2_q <= req_data_in;
        cnt_q <= CNT_LOAD;
      end else if ((state_q == S_EXEC) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Response is a single-cycle pulse; every other edge returns it to zero.
      resp_q <= finish ? res_code : RESP_NONE;
      data_q <= finish ? res_data : '0;
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + DROP_ONE;
      end
    end
  end

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign drop_cnt = drop_q;

endmodule
